// File: rtl/crc_pkg.sv
// Shared CRC definitions: checker FSM states and a byte-wide MSB-first CRC step.
// The CRC register is kept left-aligned in 32 bits, so one function serves every width from 8 to 32.
package crc_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    STATUS = 2'd2
  } state_t;

  localparam int CRC_REG_W = 32;

  // crc and poly are MSB-aligned; unused low bits stay zero because poly's low bits are zero.
  function automatic logic [CRC_REG_W-1:0] crcByteStep(
    input logic [CRC_REG_W-1:0] crc,
    input logic [7:0]           data,
    input logic [CRC_REG_W-1:0] poly
  );
    logic [CRC_REG_W-1:0] c;
    c = crc ^ {data, {(CRC_REG_W-8){1'b0}}};
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_REG_W-1] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_delay_line.sv
// CB-byte delay line feeding a one-entry output register; emitted bytes lag accepted bytes by CB.
// Output register holds while out_valid && !out_ready; the caller only emits when the register is free.
module crc_delay_line #(
  parameter int CB = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       emit,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic [CB-1:0][7:0] line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line      <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      if (shift_en) begin
        line[0] <= in_data;
        for (int i = 1; i < CB; i++) begin
          line[i] <= line[i-1];
        end
      end
      // The oldest byte leaves on the same accept that shifts the new one in.
      if (emit) begin
        out_data  <= line[CB-1];
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Streams a frame's payload while checking its trailing CRC; payload lags input by CB bytes, status one cycle after last accept.
// Input stalls while the output register is full and not taken, and during the STATUS cycle; optional errCount_o via CRC_FRAME_CHECKER_ERRCOUNT_EN.
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int                   POLYWIDTH = 8,
  parameter logic [POLYWIDTH-1:0] POLY      = 8'h07
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inValid_i,
  output logic        inReady_o,
  input  logic [7:0]  inData_i,
  input  logic        inLast_i,
  output logic        outValid_o,
  input  logic        outReady_i,
  output logic [7:0]  outData_o,
  output logic        outLast_o,
  output logic        statusValid_o,
`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
  output logic        statusOk_o,
  output logic [15:0] errCount_o
`else
  output logic        statusOk_o
`endif
);

  localparam int CB = POLYWIDTH / 8;
  localparam int CW = $clog2(CB + 1);
  localparam logic [CRC_REG_W-1:0] POLY_AL = CRC_REG_W'(POLY) << (CRC_REG_W - POLYWIDTH);

  state_t               state;
  logic [CRC_REG_W-1:0] crc_q;
  logic [CRC_REG_W-1:0] crc_next;
  logic [CW-1:0]        fill_cnt;
  logic                 status_vld_q;
  logic                 status_ok_q;
  logic                 accept;
  logic                 emit;
  logic                 frame_bad;

  assign inReady_o     = (!outValid_o || outReady_i) && (state != STATUS);
  assign accept        = inValid_i && inReady_o;
  assign emit          = accept && (state == STREAM);
  assign crc_next      = crcByteStep(crc_q, inData_i, POLY_AL);
  // A frame ending while still filling carries no payload beyond its CRC: runt.
  assign frame_bad     = (state == FILL) || (crc_next != '0);
  assign statusValid_o = status_vld_q;
  assign statusOk_o    = status_ok_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= FILL;
      crc_q        <= '0;
      fill_cnt     <= '0;
      status_vld_q <= 1'b0;
      status_ok_q  <= 1'b0;
    end else begin
      status_vld_q <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            crc_q    <= crc_next;
            fill_cnt <= fill_cnt + 1'b1;
            if (inLast_i) begin
              state        <= STATUS;
              status_vld_q <= 1'b1;
              status_ok_q  <= 1'b0;
            end else if (fill_cnt == CW'(CB - 1)) begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            crc_q <= crc_next;
            if (inLast_i) begin
              state        <= STATUS;
              status_vld_q <= 1'b1;
              status_ok_q  <= !frame_bad;
            end
          end
        end
        STATUS: begin
          state    <= FILL;
          crc_q    <= '0;
          fill_cnt <= '0;
        end
        default: state <= FILL;
      endcase
    end
  end

  crc_delay_line #(
    .CB(CB)
  ) u_delay_line (
    .clk       (clk_i),
    .rst       (rst_i),
    .shift_en  (accept),
    .emit      (emit),
    .in_data   (inData_i),
    .in_last   (inLast_i),
    .out_ready (outReady_i),
    .out_valid (outValid_o),
    .out_data  (outData_o),
    .out_last  (outLast_o)
  );

`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errCount_o <= 16'h0000;
    end else if (accept && inLast_i && frame_bad && (errCount_o != 16'hFFFF)) begin
      errCount_o <= errCount_o + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench for crc_frame_checker (POLYWIDTH=8, POLY=0x07); expected bytes/status queued at drive time.
module tb_crc_frame_checker;

  localparam int          POLYWIDTH = 8;
  localparam logic [7:0]  POLY      = 8'h07;
  localparam int          CB        = POLYWIDTH / 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inValid_i;
  logic        inReady_o;
  logic [7:0]  inData_i;
  logic        inLast_i;
  logic        outValid_o;
  logic        outReady_i;
  logic [7:0]  outData_o;
  logic        outLast_o;
  logic        statusValid_o;
  logic        statusOk_o;
`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
  logic [15:0] errCount_o;
`endif

  always #5 clk_i = ~clk_i;

  crc_frame_checker #(
    .POLYWIDTH(POLYWIDTH),
    .POLY     (POLY)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inValid_i    (inValid_i),
    .inReady_o    (inReady_o),
    .inData_i     (inData_i),
    .inLast_i     (inLast_i),
    .outValid_o   (outValid_o),
    .outReady_i   (outReady_i),
    .outData_o    (outData_o),
    .outLast_o    (outLast_o),
    .statusValid_o(statusValid_o),
`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
    .statusOk_o   (statusOk_o),
    .errCount_o   (errCount_o)
`else
    .statusOk_o   (statusOk_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
  } out_t;

  typedef struct {
    logic        ok;
    logic [15:0] cnt;
  } st_t;

  out_t        exp_out[$];
  st_t         exp_st[$];
  logic [15:0] err_model = 16'h0000;
  logic        bp_en = 1'b0;
  logic [7:0]  q[$];

  // Bit-serial reference CRC (feedback form), independent of the DUT's byte-XOR formulation.
  function automatic logic [POLYWIDTH-1:0] model_crc(input logic [7:0] b[$]);
    logic [POLYWIDTH-1:0] c;
    logic                 fb;
    c = '0;
    foreach (b[i]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[POLYWIDTH-1] ^ b[i][j];
        c  = c << 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    @(negedge clk_i);
    inValid_i = 1'b1;
    inData_i  = d;
    inLast_i  = l;
    while (!inReady_o && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    if (!inReady_o) check("in_ready_timeout", {31'b0, inReady_o}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    int   n;
    logic bad;
    st_t  s;
    out_t o;
    n   = b.size();
    bad = (n <= CB) || (model_crc(b) != '0);
    if (bad && err_model != 16'hFFFF) err_model = err_model + 16'h1;
    s.ok  = !bad;
    s.cnt = err_model;
    exp_st.push_back(s);
    for (int i = 0; i < n - CB; i++) begin
      o.data = b[i];
      o.last = (i == n - CB - 1);
      exp_out.push_back(o);
    end
    for (int i = 0; i < n; i++) send_byte(b[i], i == n - 1);
    @(posedge clk_i);
    #1;
    inValid_i = 1'b0;
    inLast_i  = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (outValid_o && outReady_i) begin
        if (exp_out.size() == 0) begin
          check("out_unexpected", {31'b0, outValid_o}, 32'd0);
        end else begin
          out_t e;
          e = exp_out.pop_front();
          check("out_data", {24'b0, outData_o}, {24'b0, e.data});
          check("out_last", {31'b0, outLast_o}, {31'b0, e.last});
        end
      end
      if (statusValid_o) begin
        if (exp_st.size() == 0) begin
          check("status_unexpected", {31'b0, statusValid_o}, 32'd0);
        end else begin
          st_t e;
          e = exp_st.pop_front();
          check("status_ok", {31'b0, statusOk_o}, {31'b0, e.ok});
`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
          check("err_count", {16'b0, errCount_o}, {16'b0, e.cnt});
`endif
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (bp_en) begin
      #1;
      outReady_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         t;
    int         len;
    rst_i      = 1'b1;
    inValid_i  = 1'b0;
    inData_i   = 8'h00;
    inLast_i   = 1'b0;
    outReady_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_out_valid", {31'b0, outValid_o}, 32'd0);
    check("rst_out_data", {24'b0, outData_o}, 32'd0);
    check("rst_out_last", {31'b0, outLast_o}, 32'd0);
    check("rst_status_valid", {31'b0, statusValid_o}, 32'd0);
    check("rst_status_ok", {31'b0, statusOk_o}, 32'd0);
    check("rst_in_ready", {31'b0, inReady_o}, 32'd1);
`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
    check("rst_err_count", {16'b0, errCount_o}, 32'd0);
`endif
    rst_i = 1'b0;

    // Good two-byte frame, then statusOk must hold afterwards.
    q.delete(); q.push_back(8'h01); q.push_back(8'h07);
    send_frame(q);
    repeat (4) @(negedge clk_i);
    check("status_ok_hold", {31'b0, statusOk_o}, 32'd1);

    q.delete(); q.push_back(8'h01); q.push_back(8'h08);
    send_frame(q);

    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    q.push_back(8'hF4);
    send_frame(q);

    // Runt: one byte with last.
    q.delete(); q.push_back(8'h55);
    send_frame(q);

    // Output backpressure held 5 cycles mid-frame.
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(8'hA0 + 8'(i));
    q.push_back(model_crc(q));
    @(posedge clk_i);
    #1;
    outReady_i = 1'b0;
    fork
      send_frame(q);
    join_none
    t = 0;
    @(negedge clk_i);
    while (!outValid_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    check("bp_out_valid_seen", {31'b0, outValid_o}, 32'd1);
    d = outData_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_in_ready_low", {31'b0, inReady_o}, 32'd0);
      check("bp_out_valid_hold", {31'b0, outValid_o}, 32'd1);
      check("bp_out_data_stable", {24'b0, outData_o}, {24'b0, d});
    end
    @(posedge clk_i);
    #1;
    outReady_i = 1'b1;
    wait fork;

    // Random frames under random output backpressure; some corrupted.
    bp_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      q.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      q.push_back(model_crc(q));
      if (f[0]) q[len] = q[len] ^ 8'h10;
      send_frame(q);
    end
    bp_en = 1'b0;
    @(posedge clk_i);
    #2;
    outReady_i = 1'b1;

    // Reset after 3 bytes of a frame: no status, counter cleared, next frame good.
    begin
      out_t o;
      o.last = 1'b0;
      o.data = 8'hB1; exp_out.push_back(o);
      o.data = 8'hB2; exp_out.push_back(o);
    end
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    @(posedge clk_i);
    #1;
    inValid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    err_model = 16'h0000;
    repeat (2) @(posedge clk_i);
    #1;
    check("midrst_out_valid", {31'b0, outValid_o}, 32'd0);
    check("midrst_status_valid", {31'b0, statusValid_o}, 32'd0);
`ifdef CRC_FRAME_CHECKER_ERRCOUNT_EN
    check("midrst_err_count", {16'b0, errCount_o}, 32'd0);
`endif
    rst_i = 1'b0;
    q.delete(); q.push_back(8'h01); q.push_back(8'h07);
    send_frame(q);

    t = 0;
    while ((exp_out.size() != 0 || exp_st.size() != 0) && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    check("sb_out_drained", exp_out.size(), 32'd0);
    check("sb_status_drained", exp_st.size(), 32'd0);
    repeat (5) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_checker.md
CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

Interface
REQ-001 SHALL have parameter POLYWIDTH, default 8, meaning CRC width in bits; it must be a multiple of 8, range 8..32.
REQ-002 SHALL have parameter POLY, default 8'h07, meaning the generator polynomial without the implicit top bit.
REQ-003 SHALL have ports clk_i (in, 1, single clock) and rst_i (in, 1, reset); reset is asynchronous and active-high.
REQ-004 SHALL have input stream ports: inValid_i (in, 1, byte valid), inReady_o (out, 1, byte accepted when high with inValid_i), inData_i (in, 8, byte), inLast_i (in, 1, last byte of frame).
REQ-005 SHALL have output stream ports: outValid_o (out, 1), outReady_i (in, 1), outData_o (out, 8, payload byte), outLast_o (out, 1, last payload byte).
REQ-006 SHALL have status ports: statusValid_o (out, 1, one-cycle event), statusOk_o (out, 1, frame CRC correct).

Function
REQ-007 SHALL compute the CRC MSB-first with init 0, no reflection and no XorOut, over all bytes of a frame including the appended CB = POLYWIDTH/8 CRC bytes; the frame is good iff the final remainder is 0.
REQ-008 SHALL update the CRC register by one full byte (8 steps) per accepted input byte.
REQ-009 SHALL hold the most recent CB accepted bytes in a delay line; each accepted byte arriving while the line is full pushes the oldest byte into the output register, so output lags input by CB bytes.
REQ-010 SHALL set outLast_o on the byte pushed out by the accepted byte that carries inLast_i; the CB bytes left in the delay line are the CRC and are dropped, never output.
REQ-011 SHALL drive inReady_o = (!outValid_o || outReady_i) && state != STATUS.
REQ-012 SHALL hold outData_o, outLast_o and outValid_o stable while outValid_o && !outReady_i.
REQ-013 SHALL use states FILL (delay line not yet full; no byte emitted), STREAM (line full; each accept emits) and STATUS (one cycle; statusValid_o=1).
- FILL goes to STREAM after the CB-th accept.
- FILL or STREAM goes to STATUS on an accept with inLast_i.
- STATUS goes to FILL unconditionally, clearing the CRC register and the fill counter.
REQ-014 SHALL treat a runt frame (inLast_i within the first CB bytes) as bad: statusOk_o=0 and no bytes output.
REQ-015 SHALL pulse statusValid_o exactly one cycle, the cycle after the last byte is accepted, independent of whether the payload last byte has yet left the output register.
REQ-016 SHALL hold statusOk_o at its value until the next status event.
REQ-017 SHALL permit a new frame's first byte on the cycle after STATUS, with no bubble beyond the STATUS cycle.

Reset
REQ-018 SHALL on rst_i force: state FILL, CRC register 0, fill counter 0, delay line 0, outValid_o=0, outLast_o=0, outData_o=0, statusValid_o=0, statusOk_o=0.
REQ-019 SHALL discard any partial frame on reset mid-frame, with no status event and no outLast_o.

Configuration
REQ-020 SHALL, with macro CRC_FRAME_CHECKER_ERRCOUNT_EN defined, add output errCount_o (16 bits):
- increments on each status event with statusOk_o=0;
- saturates at 16'hFFFF;
- resets to 0.
REQ-021 SHALL, without CRC_FRAME_CHECKER_ERRCOUNT_EN, have no errCount_o port and no counter logic; all other behaviour is identical.

Structure
REQ-022 SHALL place the state enum (FILL, STREAM, STATUS) and the function crcByteStep(crc, byte, poly) in a shared package crc_pkg, reusable by CRC generators.
REQ-023 SHALL implement the delay line and output register in sub-module crc_delay_line (parameter depth CB), with the CRC logic and FSM in the top module.

Verification
REQ-024 SHALL cover: POLYWIDTH=8, frame {0x01, 0x07} -> out 0x01 with outLast_o=1, status ok=1.
REQ-025 SHALL cover: frame {0x01, 0x08} -> out 0x01 with outLast_o=1, status ok=0; with the macro defined, errCount_o=1.
REQ-026 SHALL cover: ASCII "123456789" followed by 0xF4 -> the 9 payload bytes output in order, last on '9', ok=1.
REQ-027 SHALL cover: single-byte frame {0x55} with inLast_i -> no output, status ok=0 (runt).
REQ-028 SHALL cover: outReady_i held low 5 cycles mid-frame -> inReady_o low, outData_o stable, no byte lost or duplicated.
REQ-029 SHALL cover: rst_i asserted after 3 bytes of a frame, then frame {0x01, 0x07} -> no status for the aborted frame, then ok=1.
